// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and default widths for the zone scheduler.
package alarm_pkg;
    localparam int DTF_W_DEF = 5;
    localparam int RTR_W_DEF = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ARM,
        S_WAIT,
        S_ALARM,
        S_CLEAR,
        S_COOLDOWN
    } state_t;
endpackage

// File: rtl/alarm_zone_scheduler_rr_pick.sv
// rr_pick: first set request at or after the pointer, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int ZW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [ZW-1:0] i_ptr,
    output logic          o_hit,
    output logic [ZW-1:0] o_idx
);
    logic [ZW-1:0] w_j;

    // Walk offsets from far to near so the nearest request overwrites last.
    always_comb begin
        o_hit = |i_req;
        o_idx = '0;
        w_j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = ZW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) o_idx = w_j;
        end
    end
endmodule

// File: rtl/alarm_zone_scheduler.sv
// alarm_zone_scheduler: round-robin sharing of one alarm unit across window-sensor zones.
module alarm_zone_scheduler
    import alarm_pkg::*;
#(
    parameter int N_ZONES = 4,
    parameter int DTF_W   = DTF_W_DEF,
    parameter int RTR_W   = RTR_W_DEF,
    parameter int ZW      = $clog2(N_ZONES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_ZONES-1:0]       ws_zone,
    input  logic [N_ZONES-1:0]       zone_mask,
    input  logic [N_ZONES*DTF_W-1:0] dtf_cfg,
    input  logic [RTR_W-1:0]         rtr_cfg,
    input  logic                     tick,
    input  logic                     alarm_active,
    input  logic                     ack,
    input  logic                     clr_hist,
    output logic                     ws_out,
    output logic                     RUN,
    output logic                     CLR_WS,
    output logic                     restart,
    output logic [DTF_W-1:0]         DTF,
    output logic [RTR_W-1:0]         RTR,
    output logic [ZW-1:0]            cur_zone,
    output logic                     busy,
    output logic                     fired,
    output logic [N_ZONES-1:0]       zone_hist
);
    state_t              r_state;
    logic [ZW-1:0]       r_ptr;
    logic [RTR_W-1:0]    r_cnt;
    logic                w_hit;
    logic [ZW-1:0]       w_idx;
    logic [ZW-1:0]       w_next_ptr;
    logic                w_cur_ws;
    logic [N_ZONES-1:0]  w_set;

    rr_pick #(.N(N_ZONES), .ZW(ZW)) u_pick (
        .i_req (ws_zone & zone_mask),
        .i_ptr (r_ptr),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    assign w_cur_ws   = ws_zone[cur_zone];
    assign w_next_ptr = (int'(cur_zone) == N_ZONES - 1) ? '0 : cur_zone + 1'b1;
    assign w_set      = (r_state == S_WAIT && alarm_active) ? N_ZONES'(1) << cur_zone : '0;

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            ws_out    <= 1'b0;
            RUN       <= 1'b0;
            CLR_WS    <= 1'b0;
            restart   <= 1'b0;
            DTF       <= '0;
            RTR       <= '0;
            cur_zone  <= '0;
            busy      <= 1'b0;
            fired     <= 1'b0;
            zone_hist <= '0;
        end else begin
            CLR_WS    <= 1'b0;
            restart   <= 1'b0;
            zone_hist <= (clr_hist ? '0 : zone_hist) | w_set;
            case (r_state)
                S_IDLE: if (en) r_state <= S_SCAN;
                S_SCAN: begin
                    if (!en) r_state <= S_IDLE;
                    else if (w_hit) begin
                        r_state  <= S_ARM;
                        cur_zone <= w_idx;
                        DTF      <= dtf_cfg[w_idx*DTF_W +: DTF_W];
                        RTR      <= rtr_cfg;
                        RUN      <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_ARM: begin
                    r_state <= S_WAIT;
                    ws_out  <= w_cur_ws;
                end
                S_WAIT: begin
                    if (alarm_active) begin
                        r_state <= S_ALARM;
                        ws_out  <= 1'b1;
                        fired   <= 1'b1;
                    end else if (!w_cur_ws || !en) begin
                        r_state <= S_CLEAR;
                        ws_out  <= 1'b0;
                        RUN     <= 1'b0;
                        CLR_WS  <= 1'b1;
                        restart <= 1'b1;
                    end
                end
                S_ALARM: begin
                    if (ack) begin
                        r_state <= S_CLEAR;
                        ws_out  <= 1'b0;
                        RUN     <= 1'b0;
                        fired   <= 1'b0;
                        CLR_WS  <= 1'b1;
                        restart <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_ptr   <= w_next_ptr;
                    r_cnt   <= rtr_cfg;
                    r_state <= en ? S_COOLDOWN : S_IDLE;
                    busy    <= en;
                end
                S_COOLDOWN: begin
                    if (!en || r_cnt == '0) begin
                        r_state <= en ? S_SCAN : S_IDLE;
                        busy    <= 1'b0;
                    end else if (tick) r_cnt <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alarm_zone_scheduler.md
Name: alarm_zone_scheduler

Overview:
Controller that shares the single alarm unit (top_alarm) between N window-sensor zones. It round-robin scans the zone sensors, and for each open zone it:
- drives the alarm unit's ws, RUN, DTF and RTR inputs;
- waits for the alarm unit's active output, or for the zone to close;
- sequences the CLR_WS/restart clear and a cooldown before serving the next zone.

It sits between the house sensor inputs and top_alarm, and reports the tripped zone to the thermostat/UI logic.

Parameters:
N_ZONES, 4, number of window-sensor zones (2..8)
DTF_W, 5, width of per-zone delay-to-fire value
RTR_W, 6, width of retry/cooldown value
ZW, $clog2(N_ZONES), zone index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
en  in  1  system armed; low forces shutdown sequence
ws_zone  in  N_ZONES  raw window-open flags, one per zone
zone_mask  in  N_ZONES  1 = zone enabled for scanning
dtf_cfg  in  N_ZONES*DTF_W  packed per-zone DTF, zone i at [i*DTF_W +: DTF_W]
rtr_cfg  in  RTR_W  cooldown length in tick units, also forwarded as RTR
tick  in  1  cooldown time-base strobe (1-cycle)
alarm_active  in  1  active output of the alarm unit
ack  in  1  user acknowledge of a fired alarm
clr_hist  in  1  clears zone_hist
ws_out  out  1  ws to alarm unit
RUN  out  1  RUN to alarm unit
CLR_WS  out  1  CLR_WS to alarm unit (1-cycle pulse)
restart  out  1  restart to alarm unit (1-cycle pulse)
DTF  out  DTF_W  DTF to alarm unit, registered
RTR  out  RTR_W  RTR to alarm unit, registered
cur_zone  out  ZW  zone currently served
busy  out  1  high in ARM/WAIT/ALARM/CLEAR/COOLDOWN
fired  out  1  high in ALARM
zone_hist  out  N_ZONES  sticky per-zone fired history

Behaviour:
- All outputs are registered. With rst=0 at a clk edge, every output goes to 0, the FSM goes to IDLE, and the rr pointer goes to 0. This holds mid-operation.
- States: IDLE, SCAN, ARM, WAIT, ALARM, CLEAR, COOLDOWN.
- IDLE:
  - Outputs quiescent.
  - en=1 -> SCAN.
- SCAN:
  - req = ws_zone & zone_mask.
  - Pick the first set bit at or after the rr pointer, wrapping modulo N_ZONES.
  - None set -> stay in SCAN.
  - en=0 -> IDLE.
  - Hit -> ARM, with cur_zone=hit and DTF=dtf_cfg slice of hit.
- ARM (1 cycle):
  - RUN=1, RTR=rtr_cfg, ws_out=0.
  - -> WAIT.
  - Latency: open zone sampled in SCAN at edge t; DTF/cur_zone valid after t+1; ws_out=1 after t+2.
- WAIT:
  - ws_out=ws_zone[cur_zone], RUN=1.
  - alarm_active=1 -> ALARM, and set zone_hist[cur_zone].
  - Else ws_zone[cur_zone]=0 -> CLEAR (abort, no history).
  - Else en=0 -> CLEAR.
  - alarm_active has priority over zone-close in the same cycle.
- ALARM:
  - fired=1, RUN=1; ws_out holds 1 regardless of the sensor.
  - Leaves only on ack=1 -> CLEAR.
  - en=0 is ignored here: a fired alarm needs ack.
- CLEAR (1 cycle):
  - CLR_WS=1, restart=1, RUN=0, ws_out=0.
  - rr pointer = cur_zone+1 (wrap).
  - en=0 -> IDLE; else -> COOLDOWN, with counter loaded from rtr_cfg.
- COOLDOWN:
  - Counter decrements on tick.
  - Exits to SCAN in the cycle after the counter reaches 0; rtr_cfg=0 gives exactly 1 COOLDOWN cycle.
  - en=0 -> IDLE immediately.
  - Sensors are ignored during COOLDOWN.
- zone_hist: cleared by clr_hist. If clr_hist and a set occur in the same cycle, the set wins for that bit.
- zone_mask and dtf_cfg changes take effect only at the next SCAN/ARM. DTF is frozen while busy.
- A zone masked off while it is being served does not abort; the sequence completes.

Decomposition:
- Shared package alarm_pkg:
  - state encoding enum (IDLE..COOLDOWN);
  - default widths DTF_W=5, RTR_W=6.
- One sub-module, rr_pick: combinational round-robin first-set finder with wrap (req, ptr -> hit, idx).
- FSM, cooldown counter and output registers stay in alarm_zone_scheduler.

Test Plan:
- Reset mid-WAIT: rst=0 for 1 edge while zone 2 is served -> all outputs 0, FSM in IDLE; rst=1 with en=1 -> SCAN from zone 0.
- Single zone fire:
  - Stimulus: en=1, mask=4'b1111, ws_zone=4'b0010, dtf zone1=5'd12.
  - Response: cur_zone=1, DTF=12 and RUN=1 one cycle later; ws_out=1 the next cycle.
  - Then alarm_active=1 -> fired=1, zone_hist=4'b0010.
  - Then ack -> one cycle of CLR_WS=restart=1.
- Round-robin fairness:
  - Stimulus: ws_zone=4'b1011 held, alarm unit never fires, each zone closed then reopened after its serve.
  - Response: served order 0,1,3,0.
  - Masked zone (mask=4'b1101) with ws=4'b0010 is never served.
- Abort on close: zone 3 open, drop ws_zone[3] before alarm_active -> CLEAR pulse, zone_hist unchanged, COOLDOWN.
- Cooldown length: rtr_cfg=6'd3, tick every 4 cycles -> COOLDOWN lasts through 3 ticks then SCAN; rtr_cfg=0 -> exactly 1 COOLDOWN cycle.
- en=0 paths:
  - In WAIT -> CLEAR then IDLE.
  - In ALARM -> stays in ALARM until ack, then CLEAR then IDLE.
  - Simultaneous alarm_active and zone-close in WAIT -> ALARM.
